// File: rtl/hazard_pkg.sv
// Shared constants for the decode-stage hazard scoreboard: stall reason codes and
// default parameter values.
package hazard_pkg;

  // Stall reason encoding driven on stall_reason.
  localparam logic [1:0] HZ_NONE = 2'd0;
  localparam logic [1:0] HZ_RAW  = 2'd1;
  localparam logic [1:0] HZ_WAW  = 2'd2;
  localparam logic [1:0] HZ_EXT  = 2'd3;

  // Default parameter values.
  localparam int unsigned DEF_NREG     = 16;
  localparam int unsigned DEF_NRD      = 2;
  localparam int unsigned DEF_MAX_LAT  = 3;
  localparam int unsigned DEF_ZERO_REG = 1;
  localparam int unsigned DEF_SCW      = 16;

  // Priority encode of the hazard sources: external freeze dominates, then RAW, then WAW.
  function automatic logic [1:0] hz_encode(input logic ext, input logic raw, input logic waw);
    logic [1:0] code;
    code = HZ_NONE;
    if (ext) begin
      code = HZ_EXT;
    end else if (raw) begin
      code = HZ_RAW;
    end else if (waw) begin
      code = HZ_WAW;
    end
    return code;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: cycles remaining before a consumer of this register may issue.
// A load overrides the per-cycle decrement; the count rests at zero.
module hazard_sb_entry #(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_d;

  // Next count: load wins, otherwise count down towards zero.
  always_comb begin
    cnt_d = cnt;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt != '0) begin
      cnt_d = cnt - CW'(1);
    end
  end

  // Countdown register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW/WAW hazard unit built on a per-register countdown scoreboard.
// Each issued writer loads its destination with (latency - 1); a reader stalls while any
// enabled source has a non-zero count, a writer stalls while the pending write would land
// after its own. Outputs are combinational from the registered counts and decode inputs.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG     = DEF_NREG,
  parameter int unsigned NRD      = DEF_NRD,
  parameter int unsigned MAX_LAT  = DEF_MAX_LAT,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG,
  parameter int unsigned SCW      = DEF_SCW,
  localparam int unsigned RW      = $clog2(NREG),
  localparam int unsigned CW      = $clog2(MAX_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [NRD*RW-1:0] id_rs,
  input  logic [NRD-1:0]    id_rs_en,
  input  logic [RW-1:0]     id_rd,
  input  logic              id_rd_en,
  input  logic [CW-1:0]     id_lat,
  input  logic              flush,
  input  logic              ext_stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              stall,
  output logic [1:0]        stall_reason,
  output logic [SCW-1:0]    stall_cycles
);

  logic [CW-1:0]   cnt [NREG];
  logic [NREG-1:0] load;
  logic [CW-1:0]   lat_eff;
  logic [CW-1:0]   load_val;
  logic [RW-1:0]   rs_id [NRD];
  logic            live;
  logic            raw_hit;
  logic            raw;
  logic            waw;
  logic            hz;
  logic            issue;

  // Register 0 is hard-wired and never tracked when ZERO_REG is set.
  function automatic logic excluded(input logic [RW-1:0] r);
    return (ZERO_REG != 0) && (r == '0);
  endfunction

  // Illegal latencies (0 or above MAX_LAT) behave as the worst case.
  always_comb begin
    lat_eff = id_lat;
    if (id_lat == '0 || 32'(id_lat) > MAX_LAT) begin
      lat_eff = CW'(MAX_LAT);
    end
    load_val = lat_eff - CW'(1);
  end

  // Split the packed source field into per-port ids.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rs_id[i] = id_rs[i*RW +: RW];
    end
  end

  // RAW: any enabled source whose producer has not yet reached forwarding.
  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (id_rs_en[i] && !excluded(rs_id[i]) && (cnt[rs_id[i]] != '0)) begin
        raw_hit = 1'b1;
      end
    end
  end

  // Hazard reduce and pipeline controls; a squashed instruction never hazards.
  always_comb begin
    live         = id_valid & ~flush;
    raw          = live & raw_hit;
    waw          = live & id_rd_en & ~excluded(id_rd) & (cnt[id_rd] > lat_eff);
    hz           = raw | waw | ext_stall;
    stall        = hz;
    pc_write     = ~hz;
    if_id_write  = ~hz;
    stall_reason = hz_encode(ext_stall, raw, waw);
    issue        = live & ~hz;
  end

  // One-hot load strobe for the destination of the issuing instruction.
  always_comb begin
    load = '0;
    for (int r = 0; r < NREG; r++) begin
      if (issue && id_rd_en && (id_rd == RW'(r)) && !excluded(RW'(r))) begin
        load[r] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_entry
    hazard_sb_entry #(
      .CW (CW)
    ) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[g]),
      .load_val (load_val),
      .cnt      (cnt[g])
    );
  end

  // Saturating count of bubble cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + SCW'(1);
    end
  end

`ifndef SYNTHESIS
  // Flag writers presented with an out-of-range latency.
  always @(posedge clk) begin
    if (rst_n && id_valid && !flush && id_rd_en) begin
      assert (id_lat != '0 && 32'(id_lat) <= MAX_LAT)
        else $error("hazard_scoreboard: illegal id_lat %0d", id_lat);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (ZERO_REG=1 and ZERO_REG=0) share directed
// decode stimulus. A model tracking each register's absolute "ready cycle" predicts all
// outputs every cycle; literal checks pin the scenarios' hand-derived timings.
module tb_hazard_scoreboard;

  localparam int NREG = 16;
  localparam int RW   = 4;
  localparam int CW   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [2*RW-1:0] id_rs;
  logic [1:0]    id_rs_en;
  logic [RW-1:0] id_rd;
  logic          id_rd_en;
  logic [CW-1:0] id_lat;
  logic          flush;
  logic          ext_stall;

  logic pcw1, ifid1, stall1, pcw0, ifid0, stall0;
  logic [1:0]  rsn1, rsn0;
  logic [15:0] sc1, sc0;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: cycle of readiness per register, per instance (k=1: ZERO_REG=1).
  int cyc = 0;
  int ready [2][NREG];
  int msc [2];

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(16), .NRD(2), .MAX_LAT(3), .ZERO_REG(1), .SCW(16)) dut1 (
    .clk (clk), .rst_n (rst_n), .id_valid (id_valid), .id_rs (id_rs), .id_rs_en (id_rs_en),
    .id_rd (id_rd), .id_rd_en (id_rd_en), .id_lat (id_lat), .flush (flush),
    .ext_stall (ext_stall), .pc_write (pcw1), .if_id_write (ifid1), .stall (stall1),
    .stall_reason (rsn1), .stall_cycles (sc1)
  );

  hazard_scoreboard #(.NREG(16), .NRD(2), .MAX_LAT(3), .ZERO_REG(0), .SCW(16)) dut0 (
    .clk (clk), .rst_n (rst_n), .id_valid (id_valid), .id_rs (id_rs), .id_rs_en (id_rs_en),
    .id_rd (id_rd), .id_rd_en (id_rd_en), .id_lat (id_lat), .flush (flush),
    .ext_stall (ext_stall), .pc_write (pcw0), .if_id_write (ifid0), .stall (stall0),
    .stall_reason (rsn0), .stall_cycles (sc0)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int leff(input int lat);
    return (lat == 0 || lat > 3) ? 3 : lat;
  endfunction

  function automatic bit excl(input int k, input int r);
    return (k == 1) && (r == 0);
  endfunction

  function automatic bit m_raw(input int k);
    bit hit;
    int r;
    hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r = int'(id_rs[i*RW +: RW]);
      if (id_rs_en[i] && !excl(k, r) && ready[k][r] > cyc) hit = 1'b1;
    end
    return id_valid && !flush && hit;
  endfunction

  function automatic bit m_waw(input int k);
    int r;
    r = int'(id_rd);
    return id_valid && !flush && id_rd_en && !excl(k, r) &&
           (ready[k][r] - cyc > leff(int'(id_lat)));
  endfunction

  function automatic bit m_stall(input int k);
    return m_raw(k) || m_waw(k) || ext_stall;
  endfunction

  function automatic int m_reason(input int k);
    return ext_stall ? 3 : m_raw(k) ? 1 : m_waw(k) ? 2 : 0;
  endfunction

  // Model advance: bubble counting and destination readiness on issue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int r = 0; r < NREG; r++) ready[k][r] <= 0;
        msc[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_stall(k) && msc[k] < 65535) msc[k] <= msc[k] + 1;
        if (!m_stall(k) && id_valid && !flush && id_rd_en && !excl(k, int'(id_rd)))
          ready[k][id_rd] <= cyc + leff(int'(id_lat));
      end
      cyc <= cyc + 1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("z1_stall",  stall1, m_stall(1));
    check("z1_pcw",    pcw1,   !m_stall(1));
    check("z1_ifid",   ifid1,  !m_stall(1));
    check("z1_reason", rsn1,   m_reason(1));
    check("z1_cycles", sc1,    msc[1]);
    check("z0_stall",  stall0, m_stall(0));
    check("z0_pcw",    pcw0,   !m_stall(0));
    check("z0_ifid",   ifid0,  !m_stall(0));
    check("z0_reason", rsn0,   m_reason(0));
    check("z0_cycles", sc0,    msc[0]);
  end

  task automatic drv(input bit v, input int rs0, input bit e0, input int rs1, input bit e1,
                     input int rd, input bit rde, input int lat, input bit fl, input bit ex);
    @(posedge clk);
    #1;
    id_valid  = v;
    id_rs     = {RW'(rs1), RW'(rs0)};
    id_rs_en  = {e1, e0};
    id_rd     = RW'(rd);
    id_rd_en  = rde;
    id_lat    = CW'(lat);
    flush     = fl;
    ext_stall = ex;
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic writer(input int rd, input int lat);
    drv(1, 0, 0, 0, 0, rd, 1, lat, 0, 0);
  endtask

  task automatic reader(input int rs, input bit ex);
    drv(1, rs, 1, 0, 0, 0, 0, 1, 0, ex);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst_n = 1'b0; id_valid = 0; id_rs = '0; id_rs_en = '0; id_rd = '0; id_rd_en = 0;
    id_lat = 1; flush = 0; ext_stall = 0;

    // Reset state and reset-time external freeze.
    repeat (2) @(posedge clk);
    #2;
    check("rst_stall", stall1, 0);
    check("rst_pcw", pcw1, 1);
    check("rst_reason", rsn1, 0);
    check("rst_cycles", sc1, 0);
    ext_stall = 1; #1;
    check("rst_ext_stall", stall1, 1);
    check("rst_ext_reason", rsn1, 3);
    check("rst_ext_pcw", pcw1, 0);
    ext_stall = 0;
    @(posedge clk); #3; rst_n = 1'b1;

    // L=1 writer then back-to-back reader: no stall.
    writer(3, 1);   check("l1_wr_stall", stall1, 0);
    reader(3, 0);   check("l1_rd_stall", stall1, 0);
    idle();

    // L=3 writer to r5; reader stalls two cycles with RAW.
    writer(5, 3);   check("l3_wr_stall", stall1, 0);
    snap = int'(sc1);
    reader(5, 0);   check("l3_c1_stall", stall1, 1); check("l3_c1_reason", rsn1, 1);
    reader(5, 0);   check("l3_c2_stall", stall1, 1); check("l3_c2_reason", rsn1, 1);
    reader(5, 0);   check("l3_c3_stall", stall1, 0);
    check("l3_cycles", int'(sc1) - snap, 2);
    idle();

    // WAW: L=3 then L=1 writer to r7; one bubble, then r7 ready next cycle.
    writer(7, 3);
    writer(7, 1);   check("waw_c1_stall", stall1, 1); check("waw_c1_reason", rsn1, 2);
    writer(7, 1);   check("waw_c2_stall", stall1, 0);
    reader(7, 0);   check("waw_rd_stall", stall1, 0);
    idle();

    // Register 0: ignored with ZERO_REG=1, two-cycle stall with ZERO_REG=0.
    writer(0, 3);
    reader(0, 0);   check("r0_z1_c1", stall1, 0); check("r0_z0_c1", stall0, 1);
    check("r0_z0_reason", rsn0, 1);
    reader(0, 0);   check("r0_z0_c2", stall0, 1);
    reader(0, 0);   check("r0_z0_c3", stall0, 0);
    idle();

    // External freeze over a pending r2 hazard; reader issues when freeze lifts.
    writer(2, 3);
    for (int i = 0; i < 4; i++) begin
      reader(2, 1); check("ext_reason", rsn1, 3); check("ext_stall", stall1, 1);
    end
    reader(2, 0);   check("ext_release", stall1, 0);
    idle();

    // Disabled port is ignored; second port detects RAW.
    writer(9, 3);
    drv(1, 0, 0, 9, 0, 0, 0, 1, 0, 0); check("port1_dis", stall1, 0);
    drv(1, 0, 0, 9, 1, 0, 0, 1, 0, 0); check("port1_raw", stall1, 1);
    drv(1, 0, 0, 9, 1, 0, 0, 1, 0, 0); check("port1_ok", stall1, 0);
    idle();

    // Flushed writer never issues; flush also masks a live hazard.
    drv(1, 0, 0, 0, 0, 11, 1, 3, 1, 0); check("flush_wr", stall1, 0);
    check("flush_pcw", pcw1, 1);
    reader(11, 0);  check("flush_rd", stall1, 0);
    writer(12, 3);
    drv(1, 12, 1, 0, 0, 0, 0, 1, 1, 0); check("flush_mask", stall1, 0);
    idle();

    // Reset pulsed during a RAW stall on r4.
    writer(4, 3);
    reader(4, 0);   check("mid_pre_stall", stall1, 1);
    #1; rst_n = 1'b0; #1;
    check("mid_rst_stall", stall1, 0);
    check("mid_rst_pcw", pcw1, 1);
    check("mid_rst_cycles", sc1, 0);
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #2;
    check("mid_post_stall", stall1, 0);
    check("mid_post_cycles", sc1, 0);
    idle();
    repeat (2) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
